// File: rtl/io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// io_bus_arbiter
//
// Two-master, one-slave IO bus arbiter. An idle bus is granted to a single
// requester directly; simultaneous requests go to the master that did not own
// the bus last. The slave-side bus is a combinational mux of the owner's
// request signals while ACTIVE. A slave acknowledge completes the access in
// the same cycle, and the bus returns to IDLE for at least one cycle before
// the next grant.
//
// Optional feature (macro IO_ARB_TIMEOUT_EN): a 16-bit watchdog counts ACTIVE
// cycles. If TIMEOUT_CYCLES pass without a slave acknowledge, the arbiter
// spends one ERR cycle. In that cycle it acknowledges the owner with read data
// 16'hDEAD and sets the sticky timeout_flag. Without the macro, ACTIVE waits
// indefinitely and timeout_flag is tied low.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   mX_bus_enable/address/byte_enable/rw/write_data   master X request
//   mX_read_data, mX_acknowledge                      master X response
//   s_bus_enable/address/byte_enable/rw/write_data    shared slave bus
//   s_read_data, s_acknowledge                        slave response
//   grant                       one-hot owner (bit0 = m0), 0 when idle
//   timeout_flag, timeout_clear sticky timeout indicator and its clear
// -----------------------------------------------------------------------------
module io_bus_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_bus_enable,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [1:0]        m0_byte_enable,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_write_data,
    output logic [DATA_W-1:0] m0_read_data,
    output logic              m0_acknowledge,
    input  logic              m1_bus_enable,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [1:0]        m1_byte_enable,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic [DATA_W-1:0] m1_read_data,
    output logic              m1_acknowledge,
    output logic              s_bus_enable,
    output logic [ADDR_W-1:0] s_address,
    output logic [1:0]        s_byte_enable,
    output logic              s_rw,
    output logic [DATA_W-1:0] s_write_data,
    input  logic [DATA_W-1:0] s_read_data,
    input  logic              s_acknowledge,
    output logic [1:0]        grant,
    output logic              timeout_flag,
    input  logic              timeout_clear
);

`ifdef IO_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } state_t;

    localparam logic [15:0]       TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    localparam logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(16'hDEAD);
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1
    } state_t;
`endif

    state_t state_q, state_d;
    logic   owner_q, owner_d;            // 0 = m0, 1 = m1
    logic   last_grant_q, last_grant_d;  // owner of the previous access

`ifdef IO_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc_s;
    logic        timeout_flag_q, timeout_flag_d;
`endif

    logic              active_s;
    logic              owner_be_s;
    logic              slave_ack_s;
    logic              err_s;
    logic              done_ack_s;
    logic [DATA_W-1:0] done_rdata_s;

    assign active_s    = (state_q == ST_ACTIVE);
    assign owner_be_s  = owner_q ? m1_bus_enable : m0_bus_enable;
    // An owner that has dropped its request is aborting, so a late slave
    // acknowledge in that cycle does not complete anything.
    assign slave_ack_s = active_s & owner_be_s & s_acknowledge;

`ifdef IO_ARB_TIMEOUT_EN
    assign err_s        = (state_q == ST_ERR);
    assign done_rdata_s = err_s ? ERR_RDATA : s_read_data;
    assign cnt_inc_s    = cnt_q + 16'd1;
    assign timeout_flag = timeout_flag_q;
`else
    logic unused_timeout_clear_s;
    assign unused_timeout_clear_s = timeout_clear;
    assign err_s        = 1'b0;
    assign done_rdata_s = s_read_data;
    assign timeout_flag = 1'b0;
`endif

    assign done_ack_s = slave_ack_s | err_s;

    // Master responses: only the owner ever sees an acknowledge or read data.
    always_comb begin
        m0_acknowledge = done_ack_s & ~owner_q;
        m1_acknowledge = done_ack_s &  owner_q;
        if (m0_acknowledge) begin
            m0_read_data = done_rdata_s;
        end else begin
            m0_read_data = {DATA_W{1'b0}};
        end
        if (m1_acknowledge) begin
            m1_read_data = done_rdata_s;
        end else begin
            m1_read_data = {DATA_W{1'b0}};
        end
    end

    // Slave-side mux from the current owner; all zero outside ACTIVE.
    always_comb begin
        if (active_s) begin
            s_bus_enable = owner_be_s;
            if (owner_q) begin
                s_address     = m1_address;
                s_byte_enable = m1_byte_enable;
                s_rw          = m1_rw;
                s_write_data  = m1_write_data;
            end else begin
                s_address     = m0_address;
                s_byte_enable = m0_byte_enable;
                s_rw          = m0_rw;
                s_write_data  = m0_write_data;
            end
        end else begin
            s_bus_enable  = 1'b0;
            s_address     = {ADDR_W{1'b0}};
            s_byte_enable = 2'b00;
            s_rw          = 1'b0;
            s_write_data  = {DATA_W{1'b0}};
        end
    end

    // Grant follows the owner whenever the bus is not idle.
    always_comb begin
        if (state_q != ST_IDLE) begin
            grant = owner_q ? 2'b10 : 2'b01;
        end else begin
            grant = 2'b00;
        end
    end

    // Next-state logic: arbitration, completion, abort and timeout.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
`ifdef IO_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        timeout_flag_d = timeout_flag_q & ~timeout_clear;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m0_bus_enable && m1_bus_enable) begin
                    state_d = ST_ACTIVE;
                    owner_d = ~last_grant_q;
                end else if (m0_bus_enable) begin
                    state_d = ST_ACTIVE;
                    owner_d = 1'b0;
                end else if (m1_bus_enable) begin
                    state_d = ST_ACTIVE;
                    owner_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
`ifdef IO_ARB_TIMEOUT_EN
                // Held at zero while idle so every access starts from zero.
                cnt_d = 16'd0;
`endif
            end
            ST_ACTIVE: begin
                if (!owner_be_s) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                end else if (s_acknowledge) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                end else begin
`ifdef IO_ARB_TIMEOUT_EN
                    if (cnt_inc_s == TIMEOUT_LIM) begin
                        state_d        = ST_ERR;
                        // Setting overrides a simultaneous timeout_clear.
                        timeout_flag_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
`else
                    state_d = ST_ACTIVE;
`endif
                end
            end
`ifdef IO_ARB_TIMEOUT_EN
            ST_ERR: begin
                state_d      = ST_IDLE;
                last_grant_d = owner_q;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_grant resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
`ifdef IO_ARB_TIMEOUT_EN
            cnt_q          <= 16'd0;
            timeout_flag_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
`ifdef IO_ARB_TIMEOUT_EN
            cnt_q          <= cnt_d;
            timeout_flag_q <= timeout_flag_d;
`endif
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_bus_arbiter
//
// Scenario tasks drive the masters and a scripted slave. Every expected master
// completion (which master, which read data) is queued when the stimulus is
// driven. A negedge monitor pops the queue on each acknowledge and compares.
// -----------------------------------------------------------------------------
module tb_io_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_bus_enable, m1_bus_enable;
    logic [11:0] m0_address, m1_address;
    logic [1:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_rw, m1_rw;
    logic [15:0] m0_write_data, m1_write_data;
    logic [15:0] m0_read_data, m1_read_data;
    logic        m0_acknowledge, m1_acknowledge;
    logic        s_bus_enable;
    logic [11:0] s_address;
    logic [1:0]  s_byte_enable;
    logic        s_rw;
    logic [15:0] s_write_data;
    logic [15:0] s_read_data;
    logic        s_acknowledge;
    logic [1:0]  grant;
    logic        timeout_flag;
    logic        timeout_clear;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  who;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [1:0] g_exp [6];

    io_bus_arbiter #(
        .ADDR_W(12),
        .DATA_W(16),
`ifdef IO_ARB_TIMEOUT_EN
        .TIMEOUT_CYCLES(8)
`else
        .TIMEOUT_CYCLES(255)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .m0_bus_enable(m0_bus_enable), .m0_address(m0_address),
        .m0_byte_enable(m0_byte_enable), .m0_rw(m0_rw),
        .m0_write_data(m0_write_data), .m0_read_data(m0_read_data),
        .m0_acknowledge(m0_acknowledge),
        .m1_bus_enable(m1_bus_enable), .m1_address(m1_address),
        .m1_byte_enable(m1_byte_enable), .m1_rw(m1_rw),
        .m1_write_data(m1_write_data), .m1_read_data(m1_read_data),
        .m1_acknowledge(m1_acknowledge),
        .s_bus_enable(s_bus_enable), .s_address(s_address),
        .s_byte_enable(s_byte_enable), .s_rw(s_rw),
        .s_write_data(s_write_data), .s_read_data(s_read_data),
        .s_acknowledge(s_acknowledge),
        .grant(grant), .timeout_flag(timeout_flag), .timeout_clear(timeout_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every acknowledge must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (m0_acknowledge || m1_acknowledge)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack got ack=%b%b want none", m1_acknowledge, m0_acknowledge);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m1_acknowledge, m0_acknowledge} !== mon_e.who ||
                    m0_read_data !== (mon_e.who[0] ? mon_e.data : 16'h0000) ||
                    m1_read_data !== (mon_e.who[1] ? mon_e.data : 16'h0000)) begin
                    errors++;
                    $display("FAIL sb_ack got ack=%b%b rd0=%h rd1=%h want ack=%b data=%h",
                             m1_acknowledge, m0_acknowledge, m0_read_data, m1_read_data,
                             mon_e.who, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        m0_bus_enable = 1'b0; m1_bus_enable = 1'b0;
        m0_address = 12'h000; m1_address = 12'h000;
        m0_byte_enable = 2'b00; m1_byte_enable = 2'b00;
        m0_rw = 1'b0; m1_rw = 1'b0;
        m0_write_data = 16'h0000; m1_write_data = 16'h0000;
        s_read_data = 16'h0000; s_acknowledge = 1'b0; timeout_clear = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        m0_bus_enable = 1'b1;
        s_acknowledge = 1'b1;
        s_read_data = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL reset_grant got %b want 00", grant);
        end
        checks++;
        if (s_bus_enable !== 1'b0 || s_address !== 12'h000 || s_write_data !== 16'h0000) begin
            errors++; $display("FAIL reset_slave got en=%b addr=%h wd=%h want 0", s_bus_enable, s_address, s_write_data);
        end
        checks++;
        if ({m1_acknowledge, m0_acknowledge} !== 2'b00 || m0_read_data !== 16'h0000) begin
            errors++; $display("FAIL reset_ack got ack=%b%b rd0=%h want 0", m1_acknowledge, m0_acknowledge, m0_read_data);
        end
        checks++;
        if (timeout_flag !== 1'b0) begin
            errors++; $display("FAIL reset_flag got %b want 0", timeout_flag);
        end
        idle_inputs();
        #2 reset = 1'b0;
    endtask

    task automatic test_single_read();
        next_cycle();
        m0_bus_enable = 1'b1; m0_address = 12'h010; m0_rw = 1'b1; m0_byte_enable = 2'b11;
        @(negedge clk);
        checks++;
        if (s_bus_enable !== 1'b0) begin
            errors++; $display("FAIL rd_latency_early got %b want 0", s_bus_enable);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (s_bus_enable !== 1'b1 || grant !== 2'b01) begin
            errors++; $display("FAIL rd_grant got en=%b grant=%b want en=1 grant=01", s_bus_enable, grant);
        end
        checks++;
        if (s_address !== 12'h010 || s_rw !== 1'b1 || s_byte_enable !== 2'b11) begin
            errors++; $display("FAIL rd_slave got addr=%h rw=%b be=%b want 010 1 11", s_address, s_rw, s_byte_enable);
        end
        next_cycle();
        next_cycle();
        next_cycle();
        s_acknowledge = 1'b1; s_read_data = 16'h1234;
        exp_q.push_back('{2'b01, 16'h1234});
        next_cycle();
        s_acknowledge = 1'b0; s_read_data = 16'h0000; m0_bus_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || s_bus_enable !== 1'b0) begin
            errors++; $display("FAIL rd_idle_after got grant=%b en=%b want 00 0", grant, s_bus_enable);
        end
    endtask

    task automatic test_write_m1();
        next_cycle();
        m1_bus_enable = 1'b1; m1_address = 12'h3FF; m1_rw = 1'b0;
        m1_write_data = 16'hBEEF; m1_byte_enable = 2'b10;
        next_cycle();
        @(negedge clk);
        checks++;
        if (s_address !== 12'h3FF || s_write_data !== 16'hBEEF || s_byte_enable !== 2'b10 ||
            s_rw !== 1'b0 || s_bus_enable !== 1'b1) begin
            errors++; $display("FAIL wr_slave got addr=%h wd=%h be=%b rw=%b en=%b want 3ff beef 10 0 1",
                               s_address, s_write_data, s_byte_enable, s_rw, s_bus_enable);
        end
        checks++;
        if (grant !== 2'b10 || m0_acknowledge !== 1'b0) begin
            errors++; $display("FAIL wr_grant got grant=%b ack0=%b want 10 0", grant, m0_acknowledge);
        end
        next_cycle();
        s_acknowledge = 1'b1; s_read_data = 16'h5555;
        exp_q.push_back('{2'b10, 16'h5555});
        next_cycle();
        s_acknowledge = 1'b0; s_read_data = 16'h0000; m1_bus_enable = 1'b0;
    endtask

    task automatic test_fair();
        do_reset();
        g_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        next_cycle();
        m0_bus_enable = 1'b1; m0_rw = 1'b1; m0_address = 12'h100;
        m1_bus_enable = 1'b1; m1_rw = 1'b1; m1_address = 12'h200;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_cycle();
            if (g_exp[i] != 2'b00) begin
                s_acknowledge = 1'b1;
                s_read_data = 16'(16'hA000 + i);
                exp_q.push_back('{g_exp[i], 16'(16'hA000 + i)});
            end else begin
                s_acknowledge = 1'b0;
                s_read_data = 16'h0000;
            end
            @(negedge clk);
            checks++;
            if (grant !== g_exp[i]) begin
                errors++; $display("FAIL fair_grant cycle %0d got %b want %b", i, grant, g_exp[i]);
            end
        end
        next_cycle();
        s_acknowledge = 1'b0; s_read_data = 16'h0000;
        m0_bus_enable = 1'b0; m1_bus_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL fair_end got %b want 00", grant);
        end
    endtask

    task automatic test_abort();
        do_reset();
        next_cycle();
        m0_bus_enable = 1'b1; m0_address = 12'h020;
        next_cycle();
        m1_bus_enable = 1'b1; m1_address = 12'h030;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL abort_owner got %b want 01", grant);
        end
        next_cycle();
        m0_bus_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (s_bus_enable !== 1'b0 || m0_acknowledge !== 1'b0) begin
            errors++; $display("FAIL abort_drop got en=%b ack0=%b want 0 0", s_bus_enable, m0_acknowledge);
        end
        next_cycle();
        // Stray slave acknowledge during IDLE must be ignored.
        s_acknowledge = 1'b1; s_read_data = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || {m1_acknowledge, m0_acknowledge} !== 2'b00 || m1_read_data !== 16'h0000) begin
            errors++; $display("FAIL abort_idle got grant=%b ack=%b%b rd1=%h want 00 00 0",
                               grant, m1_acknowledge, m0_acknowledge, m1_read_data);
        end
        next_cycle();
        s_acknowledge = 1'b0; s_read_data = 16'h0000;
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_address !== 12'h030) begin
            errors++; $display("FAIL abort_next got grant=%b addr=%h want 10 030", grant, s_address);
        end
        next_cycle();
        s_acknowledge = 1'b1; s_read_data = 16'h0C0C;
        exp_q.push_back('{2'b10, 16'h0C0C});
        next_cycle();
        s_acknowledge = 1'b0; s_read_data = 16'h0000; m1_bus_enable = 1'b0;
    endtask

    task automatic test_reset_mid_active();
        next_cycle();
        m1_bus_enable = 1'b1; m1_address = 12'h055;
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_bus_enable !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got grant=%b en=%b want 10 1", grant, s_bus_enable);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (s_bus_enable !== 1'b0 || grant !== 2'b00 || m1_acknowledge !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got en=%b grant=%b ack1=%b want 0 00 0",
                               s_bus_enable, grant, m1_acknowledge);
        end
        #1 reset = 1'b0;
        m0_bus_enable = 1'b1; m0_address = 12'h066;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            errors++; $display("FAIL rstmid_tie got %b want 01", grant);
        end
        next_cycle();
        s_acknowledge = 1'b1; s_read_data = 16'h7777;
        exp_q.push_back('{2'b01, 16'h7777});
        next_cycle();
        s_acknowledge = 1'b0; s_read_data = 16'h0000;
        m0_bus_enable = 1'b0; m1_bus_enable = 1'b0;
    endtask

`ifdef IO_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        next_cycle();
        m0_bus_enable = 1'b1; m0_rw = 1'b1; m0_address = 12'h040;
        exp_q.push_back('{2'b01, 16'hDEAD});
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == 8) timeout_clear = 1'b1;
            @(negedge clk);
            checks++;
            if (s_bus_enable !== 1'b1 || m0_acknowledge !== 1'b0) begin
                errors++; $display("FAIL tmo_wait cycle %0d got en=%b ack0=%b want 1 0", c, s_bus_enable, m0_acknowledge);
            end
        end
        next_cycle();
        timeout_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (s_bus_enable !== 1'b0 || timeout_flag !== 1'b1 || m0_acknowledge !== 1'b1) begin
            errors++; $display("FAIL tmo_err got en=%b flag=%b ack0=%b want 0 1 1", s_bus_enable, timeout_flag, m0_acknowledge);
        end
        next_cycle();
        m0_bus_enable = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if (timeout_flag !== 1'b1 || grant !== 2'b00) begin
            errors++; $display("FAIL tmo_sticky got flag=%b grant=%b want 1 00", timeout_flag, grant);
        end
        next_cycle();
        timeout_clear = 1'b1;
        next_cycle();
        timeout_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout_flag !== 1'b0) begin
            errors++; $display("FAIL tmo_clear got %b want 0", timeout_flag);
        end
    endtask
`else
    task automatic test_no_timeout();
        logic seen_bad;
        seen_bad = 1'b0;
        do_reset();
        next_cycle();
        m0_bus_enable = 1'b1; m0_address = 12'h040;
        next_cycle();
        for (int c = 0; c < 40; c++) begin
            timeout_clear = c[0];
            @(negedge clk);
            if (s_bus_enable !== 1'b1 || m0_acknowledge !== 1'b0 || timeout_flag !== 1'b0) seen_bad = 1'b1;
            next_cycle();
        end
        checks++;
        if (seen_bad !== 1'b0) begin
            errors++; $display("FAIL notmo_wait got bad=%b want 0", seen_bad);
        end
        timeout_clear = 1'b0;
        m0_bus_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (s_bus_enable !== 1'b0 || timeout_flag !== 1'b0) begin
            errors++; $display("FAIL notmo_abort got en=%b flag=%b want 0 0", s_bus_enable, timeout_flag);
        end
        next_cycle();
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_write_m1();
        test_fair();
        test_abort();
        test_reset_mid_active();
`ifdef IO_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        repeat (3) next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
